// File: rtl/stack_controller_pkg.sv
// stack_controller_pkg: shared state encoding and default sizes for the operand stack controller.
package stack_controller_pkg;
    typedef enum logic {ST_IDLE, ST_REFILL} state_t;
    localparam int DATA_W      = 8;
    localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/stack_controller.sv
// stack_controller: operand stack with TOS in a register and deeper entries spilled to an external sync RAM.
// Pops that need a refill take a second cycle in ST_REFILL while the RAM read returns.
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter int DATA_W = stack_controller_pkg::DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] tos,
    output logic              ready,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic [ADDR_W:0]   cnt_m1;
    logic [ADDR_W-1:0] sp;

    assign cnt_m1 = count_q - 1'b1;
    assign sp     = empty ? '0 : cnt_m1[ADDR_W-1:0];
    assign ready  = state_q == ST_IDLE;
    assign empty  = count_q == '0;
    assign full   = count_q == FULL_CNT;
    assign count  = count_q;
    assign tos    = tos_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tos_d     = tos_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        mem_we    = 1'b0;
        mem_addr  = sp;
        mem_wdata = tos_q;
        if (state_q == ST_REFILL) begin
            tos_d   = mem_rdata;
            state_d = ST_IDLE;
        end else if (push) begin
            // push+pop on a non-empty stack simply replaces TOS
            if (pop && !empty) begin
                tos_d = din;
            end else if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_we  = !empty;
                tos_d   = din;
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else if (count_q == 1) begin
                count_d = '0;
                tos_d   = '0;
            end else begin
                mem_addr = sp - 1'b1;
                count_d  = cnt_m1;
                state_d  = ST_REFILL;
            end
        end
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule

// File: tb/tb_stack_controller.sv
// tb_stack_controller: scoreboard bench; a queue-based stack model predicts each cycle, a monitor compares.
module tb_stack_controller;
    logic       clk = 1'b0, rst_n = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
    logic [7:0] din = '0, tos, mem_wdata, mem_rdata;
    logic       ready, empty, full, overflow, underflow, mem_we;
    logic [4:0] count;
    logic [3:0] mem_addr;
    logic [7:0] stack_ram [16];
    int         total = 0, passed = 0;

    typedef struct {
        bit         comb, we, rd, rdy, ovf, unf;
        logic [3:0] addr;
        logic [7:0] wdata, tos;
        int         cnt;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    logic [7:0] stk[$];
    logic [7:0] m_tos = '0;
    bit         m_busy = 0, m_ovf = 0, m_unf = 0;

    stack_controller dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .tos(tos),
        .ready(ready), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) stack_ram[mem_addr] <= mem_wdata;
        mem_rdata <= stack_ram[mem_addr];
    end

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    task automatic step(bit ps, bit pp, logic [7:0] d, bit clr, bit rs);
        exp_t e;
        int n;
        @(negedge clk);
        push = ps; pop = pp; din = d; clr_err = clr; rst_n = !rs;
        e = '{default: 0};
        e.comb = !rs;
        n = stk.size();
        if (rs) begin
            stk.delete();
            m_busy = 0; m_ovf = 0; m_unf = 0; m_tos = '0;
        end else if (m_busy) begin
            m_busy = 0;
            m_tos = stk[$];
        end else begin
            e.rdy = 1;
            if (ps && pp && n > 0) begin
                stk[n-1] = d;
                m_tos = d;
            end else if (ps) begin
                if (n == 16) m_ovf = 1;
                else begin
                    if (n > 0) begin
                        e.we = 1; e.addr = 4'(n - 1); e.wdata = stk[n-1];
                    end
                    stk.push_back(d);
                    m_tos = d;
                end
            end else if (pp) begin
                if (n == 0) m_unf = 1;
                else if (n == 1) begin
                    void'(stk.pop_back());
                    m_tos = '0;
                end else begin
                    e.rd = 1; e.addr = 4'(n - 2);
                    void'(stk.pop_back());
                    m_busy = 1;
                end
            end
        end
        if (clr) begin m_ovf = 0; m_unf = 0; end
        e.tos = m_tos; e.cnt = stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            if (e.comb) begin
                chk("ready", int'(ready), int'(e.rdy));
                chk("mem_we", int'(mem_we), int'(e.we));
                if (e.we || e.rd) chk("mem_addr", int'(mem_addr), int'(e.addr));
                if (e.we) chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
            end
            @(posedge clk);
            #1;
            chk("tos", int'(tos), int'(e.tos));
            chk("count", int'(count), e.cnt);
            chk("empty", int'(empty), int'(e.cnt == 0));
            chk("full", int'(full), int'(e.cnt == 16));
            chk("overflow", int'(overflow), int'(e.ovf));
            chk("underflow", int'(underflow), int'(e.unf));
        end
    end

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        step(1, 0, 8'hAA, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 1, 8'h5A, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'(i + 1), 0, 0);
        step(1, 1, 8'h77, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // full-with-replace and flag set/clear collisions
        for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 1, 8'hEE, 0, 0);
        step(1, 0, 8'h01, 1, 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom),
                 $urandom_range(0, 99) < 5, $urandom_range(0, 199) < 1);
        @(negedge clk);
        push = 0; pop = 0; clr_err = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
